// File: rtl/int_src_cond_pkg.sv
// int_src_cond_pkg: interrupt channel numbering shared with the arbiter,
// plus the default conditioning parameters for the interrupt sources.
package int_src_cond_pkg;

    // Channel codes as seen by the interrupt arbiter
    typedef enum logic [1:0] {
        IR_NONE = 2'd0,
        IR_CH1  = 2'd1,
        IR_CH2  = 2'd2,
        IR_CH3  = 2'd3
    } ir_ch_e;

    localparam int NUM_IR_CH           = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_PULSE_LEN       = 2;
    localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/int_src_chan.sv
// int_src_chan: one interrupt source channel.
// Chain: 2-flop sync -> debounce -> rising-edge accept -> mask -> pulse stretch.
// Also keeps a saturating event counter and a sticky overrun flag.
// Ports: clk, CLR (async, active-high), btn (raw), mask, ovf_clr,
//        ir (request pulse), ovf (sticky overrun), evt_cnt (event count).
module int_src_chan
    import int_src_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_LEN       = DEF_PULSE_LEN,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             CLR,
    input  logic             btn,
    input  logic             mask,
    input  logic             ovf_clr,
    output logic             ir,
    output logic             ovf,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam int DBC_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int PCNT_W = $clog2(PULSE_LEN + 1);

    localparam logic [DBC_W-1:0]  DBC_MAX = DBC_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PLEN    = PCNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    logic              sync1;
    logic              sync2;
    logic              stable;
    logic              stable_nxt;
    logic [DBC_W-1:0]  dbc;
    logic [DBC_W-1:0]  dbc_nxt;
    logic [PCNT_W-1:0] pcnt;
    logic [PCNT_W-1:0] pcnt_nxt;
    logic              accept;
    logic              take;
    logic              overrun;

    always_comb begin
        stable_nxt = stable;
        dbc_nxt    = dbc;
        if (sync2 == stable) begin
            dbc_nxt = '0;
        end else if (dbc == DBC_MAX) begin
            stable_nxt = sync2;
            dbc_nxt    = '0;
        end else begin
            dbc_nxt = dbc + DBC_W'(1);
        end
    end

    // Accept on the same edge that stable flips 0->1
    assign accept  = stable_nxt & ~stable;
    assign take    = accept & ~mask;
    assign overrun = take & (pcnt != '0);

    // An event during an active pulse does not restart it
    always_comb begin
        pcnt_nxt = '0;
        if (pcnt != '0) begin
            pcnt_nxt = pcnt - PCNT_W'(1);
        end else if (take) begin
            pcnt_nxt = PLEN;
        end
    end

    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            stable  <= 1'b0;
            dbc     <= '0;
            pcnt    <= '0;
            ir      <= 1'b0;
            ovf     <= 1'b0;
            evt_cnt <= '0;
        end else begin
            sync1  <= btn;
            sync2  <= sync1;
            stable <= stable_nxt;
            dbc    <= dbc_nxt;
            pcnt   <= pcnt_nxt;
            // Registered so the request edge is glitch-free
            ir     <= (pcnt_nxt != '0);
            if (overrun) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            if (take && (evt_cnt != CNT_MAX)) begin
                evt_cnt <= evt_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/int_src_cond.sv
// int_src_cond: conditions three raw interrupt sources into request pulses.
// Ports: clk, CLR (async, active-high), btn_raw[2:0], mask[2:0], ovf_clr,
//        ir1/ir2/ir3 (requests), ovf[2:0] (sticky), evt_cnt1..3 (counts).
module int_src_cond
    import int_src_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int PULSE_LEN       = DEF_PULSE_LEN,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 CLR,
    input  logic [NUM_IR_CH-1:0] btn_raw,
    input  logic [NUM_IR_CH-1:0] mask,
    input  logic                 ovf_clr,
    output logic                 ir1,
    output logic                 ir2,
    output logic                 ir3,
    output logic [NUM_IR_CH-1:0] ovf,
    output logic [CNT_W-1:0]     evt_cnt1,
    output logic [CNT_W-1:0]     evt_cnt2,
    output logic [CNT_W-1:0]     evt_cnt3
);

    logic [NUM_IR_CH-1:0] ir_v;
    logic [CNT_W-1:0]     cnt_v [NUM_IR_CH];

    for (genvar i = 0; i < NUM_IR_CH; i++) begin : g_ch
        int_src_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .PULSE_LEN       (PULSE_LEN),
            .CNT_W           (CNT_W)
        ) u_chan (
            .clk     (clk),
            .CLR     (CLR),
            .btn     (btn_raw[i]),
            .mask    (mask[i]),
            .ovf_clr (ovf_clr),
            .ir      (ir_v[i]),
            .ovf     (ovf[i]),
            .evt_cnt (cnt_v[i])
        );
    end

    assign ir1      = ir_v[0];
    assign ir2      = ir_v[1];
    assign ir3      = ir_v[2];
    assign evt_cnt1 = cnt_v[0];
    assign evt_cnt2 = cnt_v[1];
    assign evt_cnt3 = cnt_v[2];

endmodule
